// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch-to-decode instruction stream handshake.
interface fetch_ctrl_if;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;

  modport master (output valid, output instr, output pc, input  ready);
  modport slave  (input  valid, input  instr, input  pc, output ready);
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with PC, fetch buffer and RUN/HALTED/FAULT FSM.
// Optional feature: FETCH_MISALIGN_CHK_EN traps misaligned redirects into FAULT.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_ctrl_if.master       out_if,
  output logic [31:0]        imem_addr_o,
  input  logic [31:0]        imem_instr_i,
  input  logic               redirect_valid_i,
  input  logic [31:0]        redirect_pc_i,
  input  logic               halt_req_i,
  output logic               halted_o,
  output logic               fault_o,
  output logic [31:0]        fault_pc_o
);

  localparam int              CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_FAULT} state_e;

  state_e         state_q, state_d;
  logic [63:0]    buf_q [BUF_DEPTH];
  logic [63:0]    buf_d [BUF_DEPTH];
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  tail;
  logic [31:0]    pc_q, pc_d;
  logic           pop, push, misaligned;

`ifdef FETCH_MISALIGN_CHK_EN
  assign misaligned = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign pop  = (count_q != '0) && out_if.ready;
  assign push = (state_q == ST_RUN) && !redirect_valid_i && ((count_q < DEPTH_C) || pop);
  assign tail = count_q - {{(CW-1){1'b0}}, pop};

  // Head is always entry 0; pops shift the buffer down so the outputs are pure register reads.
  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    pc_d    = pc_q;
    if (redirect_valid_i) begin
      count_d = '0;
      if (!misaligned) pc_d = redirect_pc_i & 32'hFFFF_FFFC;
    end else begin
      if (pop) begin
        for (int i = 0; i < BUF_DEPTH - 1; i++) buf_d[i] = buf_q[i+1];
      end
      if (push) begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
          if (tail == CW'(i)) buf_d[i] = {pc_q, imem_instr_i};
        end
        pc_d = pc_q + 32'd4;
      end
      count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      count_q <= '0;
      pc_q    <= RESET_PC;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // A redirect keeps HALTED even with halt_req low; the release happens on a later cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (misaligned)                           state_d = ST_FAULT;
        else if (halt_req_i && !redirect_valid_i) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (misaligned)                           state_d = ST_FAULT;
        else if (!halt_req_i && !redirect_valid_i) state_d = ST_RUN;
      end
      ST_FAULT:                                   state_d = ST_FAULT;
      default:                                    state_d = ST_RUN;
    endcase
  end

  always_comb begin
    halted_o     = (state_q == ST_HALTED);
    imem_addr_o  = pc_q;
    out_if.valid = (count_q != '0);
    out_if.pc    = buf_q[0][63:32];
    out_if.instr = buf_q[0][31:0];
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic        fault_q;
  logic [31:0] fault_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else if (misaligned && (state_q != ST_FAULT)) begin
      fault_q    <= 1'b1;
      fault_pc_q <= redirect_pc_i;
    end
  end

  assign fault_o    = fault_q;
  assign fault_pc_o = fault_pc_q;
`else
  assign fault_o    = 1'b0;
  assign fault_pc_o = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - table-driven directed bench for fetch_ctrl.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        halted, fault;
  logic [31:0] fault_pc;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .out_if           (bus.master),
    .imem_addr_o      (imem_addr),
    .imem_instr_i     (imem_instr),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .halt_req_i       (halt_req),
    .halted_o         (halted),
    .fault_o          (fault),
    .fault_pc_o       (fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign imem_instr = rom(imem_addr);

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        halt;
    logic        ready;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        ehalt;
    logic        efault;
    logic [31:0] efpc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  task automatic add(input logic rv, input logic [31:0] rpc, input logic halt, input logic ready,
                     input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                     input logic ehalt, input logic efault, input logic [31:0] efpc);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.halt = halt; v.ready = ready;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.ehalt = ehalt; v.efault = efault; v.efpc = efpc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [31:0] epc,
                            input logic [31:0] eaddr, input logic ehalt,
                            input logic efault, input logic [31:0] efpc);
    check({tag, " out_valid"}, {31'b0, bus.valid}, {31'b0, ev});
    check({tag, " imem_addr"}, imem_addr, eaddr);
    check({tag, " halted"},    {31'b0, halted}, {31'b0, ehalt});
    check({tag, " fault"},     {31'b0, fault}, {31'b0, efault});
    check({tag, " fault_pc"},  fault_pc, efpc);
    if (ev) begin
      check({tag, " out_pc"},    bus.pc, epc);
      check({tag, " out_instr"}, bus.instr, rom(epc));
    end
  endtask

  initial begin
    bus.ready = 1'b0;

    //  rv  rpc            halt rdy  ev  epc            eaddr          eh  ef  efpc
    add(0, 32'h0,          0,   1,   1,  32'h0,         32'h4,         0,  0,  32'h0);
    add(0, 32'h0,          0,   1,   1,  32'h4,         32'h8,         0,  0,  32'h0);
    add(0, 32'h0,          0,   1,   1,  32'h8,         32'hC,         0,  0,  32'h0);
    add(0, 32'h0,          0,   1,   1,  32'hC,         32'h10,        0,  0,  32'h0);
    add(0, 32'h0,          0,   0,   1,  32'hC,         32'h14,        0,  0,  32'h0);
    for (int i = 0; i < 4; i++)
      add(0, 32'h0,        0,   0,   1,  32'hC,         32'h14,        0,  0,  32'h0);
    add(0, 32'h0,          0,   1,   1,  32'h10,        32'h18,        0,  0,  32'h0);
    add(0, 32'h0,          0,   1,   1,  32'h14,        32'h1C,        0,  0,  32'h0);
    add(1, 32'h40,         0,   1,   0,  32'h0,         32'h40,        0,  0,  32'h0);
    add(0, 32'h0,          0,   1,   1,  32'h40,        32'h44,        0,  0,  32'h0);
    add(0, 32'h0,          0,   1,   1,  32'h44,        32'h48,        0,  0,  32'h0);
    add(0, 32'h0,          1,   1,   1,  32'h48,        32'h4C,        1,  0,  32'h0);
    add(0, 32'h0,          1,   1,   0,  32'h0,         32'h4C,        1,  0,  32'h0);
    add(0, 32'h0,          1,   1,   0,  32'h0,         32'h4C,        1,  0,  32'h0);
    add(0, 32'h0,          0,   1,   0,  32'h0,         32'h4C,        0,  0,  32'h0);
    add(0, 32'h0,          0,   1,   1,  32'h4C,        32'h50,        0,  0,  32'h0);
    add(0, 32'h0,          1,   0,   1,  32'h4C,        32'h54,        1,  0,  32'h0);
    add(1, 32'h100,        1,   1,   0,  32'h0,         32'h100,       1,  0,  32'h0);
    add(0, 32'h0,          0,   1,   0,  32'h0,         32'h100,       0,  0,  32'h0);
    add(0, 32'h0,          0,   1,   1,  32'h100,       32'h104,       0,  0,  32'h0);
    add(1, 32'hFFFF_FFFC,  0,   1,   0,  32'h0,         32'hFFFF_FFFC, 0,  0,  32'h0);
    add(0, 32'h0,          0,   1,   1,  32'hFFFF_FFFC, 32'h0,         0,  0,  32'h0);
    add(0, 32'h0,          0,   1,   1,  32'h0,         32'h4,         0,  0,  32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
    add(1, 32'h42,         0,   1,   0,  32'h0,         32'h4,         0,  1,  32'h42);
    add(0, 32'h0,          0,   1,   0,  32'h0,         32'h4,         0,  1,  32'h42);
`else
    add(1, 32'h42,         0,   1,   0,  32'h0,         32'h40,        0,  0,  32'h0);
    add(0, 32'h0,          0,   1,   1,  32'h40,        32'h44,        0,  0,  32'h0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 32'h0, RESET_PC, 1'b0, 1'b0, 32'h0);
    check("reset out_pc",    bus.pc, 32'h0);
    check("reset out_instr", bus.instr, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      halt_req       = vecs[i].halt;
      bus.ready      = vecs[i].ready;
      @(posedge clk);
      #1;
      check_outs($sformatf("row%0d", i + 1), vecs[i].ev, vecs[i].epc, vecs[i].eaddr,
                 vecs[i].ehalt, vecs[i].efault, vecs[i].efpc);
    end

    // Asynchronous reset pulse between clock edges.
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    bus.ready      = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async out_valid", {31'b0, bus.valid}, 32'h0);
    check("async out_pc",    bus.pc, 32'h0);
    check("async imem_addr", imem_addr, RESET_PC);
    check("async fault",     {31'b0, fault}, 32'h0);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("post_reset1", 1'b1, RESET_PC, RESET_PC + 32'h4, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check_outs("post_reset2", 1'b1, RESET_PC + 32'h4, RESET_PC + 32'h8, 1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
